mdu_seq_ctrl: RTL and testbench
===============================

// Module: mdu_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for MULT/MULTU/DIV/DIVU. Owns the HI/LO registers and
//  runs a radix-2 shift-add / restoring-divide loop over 32 iterations.
//  Sits beside the ALU in EX. Asserts busy so hazard control stalls MFHI/MFLO
//  and any further MDU op until done.
// PARAMETERS
//  WIDTH   32  operand/HI/LO width; iteration count = WIDTH
//  CNT_W    6  iteration counter width, must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk      in   1      single clock, all state updates on rising edge
//  rst_n    in   1      synchronous reset, active low
//  start    in   1      launch op; sampled only in IDLE
//  op       in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//  a        in   WIDTH  rs operand (multiplicand / dividend)
//  b        in   WIDTH  rt operand (multiplier / divisor)
//  cancel   in   1      pipeline flush; abort in-flight op
//  mthi     in   1      write hi_wdata to HI
//  mtlo     in   1      write lo_wdata to LO
//  hi_wdata in   WIDTH  MTHI data
//  lo_wdata in   WIDTH  MTLO data
//  busy     out  1      op in flight (PREP..FIX)
//  done     out  1      one-cycle pulse; HI/LO hold the new result
//  hi       out  WIDTH  HI register
//  lo       out  WIDTH  LO register
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, hi=0, lo=0,
//   counter=0. Applies mid-operation; any partial result is discarded.
//  FSM: IDLE -> PREP -> CALC (x WIDTH) -> FIX -> IDLE.
//   IDLE: start=1 & cancel=0 -> latch op, a, b; go to PREP.
//   PREP: signed ops take |a|, |b| and record the result signs; clear acc
//     and counter.
//   CALC: one iteration per cycle. Leave after counter hits WIDTH-1.
//   FIX : negate the product, or the quotient/remainder, as required.
//     Write {hi,lo}, go to IDLE.
//  Timing: start accepted at edge 0.
//   busy=1 is seen in the cycles after edges 1..WIDTH+2.
//   HI/LO are updated at edge WIDTH+3 (35).
//   done=1 is seen in the single cycle after that edge; busy=0 in that cycle.
//  MULT/MULTU: {hi,lo} = full 2*WIDTH product; signed uses two's complement.
//  DIV/DIVU: lo=quotient, hi=remainder. Signed quotient truncates toward
//   zero; remainder takes the sign of the dividend.
//   Special case: 0x8000_0000 / -1 -> lo=0x8000_0000, hi=0.
//  Divide by zero (b=0), signed or unsigned: lo=0xFFFF_FFFF, hi=a.
//   Full latency still applies.
//  start while busy: ignored (no queueing). cancel has priority over start.
//  cancel while busy: return to IDLE at the next edge. HI/LO unchanged, no done.
//  mthi/mtlo in IDLE: register written at the next edge; both may fire together.
//   If start fires in the same cycle, the mt write still lands and the op
//   proceeds; the op's result later overwrites HI/LO.
//  mthi/mtlo while busy: ignored (hazard logic must not issue them).
//  Outputs hi/lo are registered, never combinational from the loop.
// STRUCTURE
//  mdu_defs.vh: op encodings (MDU_MULTU/MULT/DIVU/DIV) and FSM state codes
//   S_IDLE/S_PREP/S_CALC/S_FIX; shared with the decoder/hazard unit.
//  Sub-module mdu_step: combinational single iteration (add-shift or
//   trial-subtract-shift) on {acc, q}; instantiated once in CALC.
//  Top holds the FSM, counter, sign flags, HI/LO, and mthi/mtlo muxing.
// TESTING
//  MULTU a=0xFFFF_FFFF b=0xFFFF_FFFF -> hi=0xFFFF_FFFE lo=0x0000_0001; done exactly at edge 35.
//  MULT a=-3 b=7 -> hi=0xFFFF_FFFF lo=0xFFFF_FFEB; busy high for 34 cycles, then one done pulse.
//  DIV a=-7 b=2 -> lo=0xFFFF_FFFD hi=0xFFFF_FFFF; DIV 0x8000_0000/-1 -> lo=0x8000_0000 hi=0.
//  DIVU a=123 b=0 -> lo=0xFFFF_FFFF hi=123; then MTHI 0xA5A5 with MTLO 0x5A5A -> both written.
//  Preload hi=1 lo=2; start MULTU, raise cancel at cycle 10 -> IDLE next edge, hi=1 lo=2, no done.
//   Repeat with rst_n=0 at cycle 10 -> hi=lo=0.
//  start while busy (second op 5 cycles in) -> ignored; only the first result and one done pulse.

Source files
------------

// File: rtl/mdu_seq_ctrl_pkg.sv
// Shared MDU encodings: op codes and sequencer state codes, also used by the
// decoder and hazard unit.
package mdu_seq_ctrl_pkg;

  localparam logic [1:0] MDU_MULTU = 2'b00;
  localparam logic [1:0] MDU_MULT  = 2'b01;
  localparam logic [1:0] MDU_DIVU  = 2'b10;
  localparam logic [1:0] MDU_DIV   = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PREP = 2'd1;
  localparam logic [1:0] S_CALC = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/mdu_seq_ctrl_step.sv
// One radix-2 iteration on {acc, q}: shift-add for multiply (multiplier in q,
// product shifts right into q), restoring trial-subtract for divide (dividend
// shifts left out of q, quotient bits shift in).
module mdu_seq_ctrl_step #(
  parameter int WIDTH = 32
) (
  input  logic             div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // Single combinational iteration; the divide path keeps the trial
  // difference only when it did not go negative.
  always_comb begin
    sum     = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    shifted = {acc, q[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, m};
    if (div) begin
      if (!(diff[WIDTH+1] | diff[WIDTH])) begin
        acc_nxt = diff[WIDTH-1:0];
        q_nxt   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = shifted[WIDTH-1:0];
        q_nxt   = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt = sum[WIDTH:1];
      q_nxt   = {sum[0], q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO. Operates on
// magnitudes and applies signs in FIX; the fixed-up result is staged one
// cycle and then written to HI/LO together with the done pulse. busy is a
// registered view of the FSM so it lines up with that write-back stage.
import mdu_seq_ctrl_pkg::*;

module mdu_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] hi_wdata,
  input  logic [WIDTH-1:0] lo_wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   acc, quo, mcand;
  logic [WIDTH-1:0]   acc_nxt, q_nxt;
  logic               neg_lo, neg_hi, sgn;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi, fix_lo, res_hi, res_lo;
  logic               wb, busy_q, done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               accept;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  // busy_q also covers the write-back cycle, so it blocks new ops until HI/LO land
  assign accept = (state == S_IDLE) && start && !cancel && !busy_q;
  assign sgn    = op_is_signed(op_q);

  mdu_seq_ctrl_step #(.WIDTH(WIDTH)) u_step (
    .div     (op_is_div(op_q)),
    .acc     (acc),
    .q       (quo),
    .m       (mcand),
    .acc_nxt (acc_nxt),
    .q_nxt   (q_nxt)
  );

  // Sign fix-up of the magnitude result, plus the divide-by-zero override
  always_comb begin
    prod = {acc, quo};
    if (neg_lo) prod = ~prod + 1'b1;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (op_is_div(op_q)) begin
      fix_lo = neg_lo ? (~quo + 1'b1) : quo;
      fix_hi = neg_hi ? (~acc + 1'b1) : acc;
      if (b_q == '0) begin
        fix_lo = '1;
        fix_hi = a_q;
      end
    end
  end

  // FSM, iteration counter, write-back handshake and HI/LO registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      wb     <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      busy_q <= (state != S_IDLE) && !cancel;
      if (wb) begin
        wb <= 1'b0;
        if (!cancel) begin
          hi_q   <= res_hi;
          lo_q   <= res_lo;
          done_q <= 1'b1;
        end
      end else if (state == S_IDLE && !busy_q) begin
        if (mthi) hi_q <= hi_wdata;
        if (mtlo) lo_q <= lo_wdata;
      end
      if (cancel) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (accept) state <= S_PREP;
          S_PREP: begin
            cnt   <= '0;
            state <= S_CALC;
          end
          S_CALC: begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
          end
          default: begin
            wb    <= 1'b1;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Operand latch and iteration datapath; no reset needed, FSM gates use
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= op;
      a_q  <= a;
      b_q  <= b;
    end
    case (state)
      S_PREP: begin
        acc    <= '0;
        neg_lo <= sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        neg_hi <= sgn & a_q[WIDTH-1];
        if (op_is_div(op_q)) begin
          quo   <= mag(a_q, sgn);
          mcand <= mag(b_q, sgn);
        end else begin
          quo   <= mag(b_q, sgn);
          mcand <= mag(a_q, sgn);
        end
      end
      S_CALC: begin
        acc <= acc_nxt;
        quo <= q_nxt;
      end
      S_FIX: begin
        res_hi <= fix_hi;
        res_lo <= fix_lo;
      end
      default: ;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Scoreboard bench for mdu_seq_ctrl: expected {hi,lo} pushed at issue,
// popped and compared on every done pulse.
module tb_mdu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, cancel, mthi, mtlo, busy, done;
  logic [1:0]  op;
  logic [31:0] a, b, hi_wdata, lo_wdata, hi, lo;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  mdu_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .mthi(mthi), .mtlo(mtlo), .hi_wdata(hi_wdata),
    .lo_wdata(lo_wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sp;
    logic signed [31:0] sq, sr;
    case (o)
      2'b00: return {32'd0, x} * {32'd0, y};
      2'b01: begin
        sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        return sp;
      end
      2'b10: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sq = $signed(x) / $signed(y);
        sr = $signed(x) % $signed(y);
        return {sr, sq};
      end
    endcase
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding op
  always @(negedge clk) begin
    if (rst_n && done) begin
      logic [63:0] e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("hi", {32'd0, hi}, {32'd0, e[63:32]});
        check("lo", {32'd0, lo}, {32'd0, e[31:0]});
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit push, input logic [63:0] e);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    if (push) exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_result(input string tag, input bit timing);
    int k = 0;
    int nb = 0;
    bit seen = 0;
    while (!seen && k < 100) begin
      @(negedge clk);
      if (done) seen = 1;
      else begin
        if (busy) nb++;
        k++;
      end
    end
    if (!seen) check({tag, "_timeout"}, 64'd0, 64'd1);
    else if (timing) begin
      check({tag, "_latency"}, k, 35);
      check({tag, "_busy_cycles"}, nb, 34);
      check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [31:0] h, input logic [31:0] l);
    @(posedge clk); #1;
    mthi = 1'b1; mtlo = 1'b1; hi_wdata = h; lo_wdata = l;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
  endtask

  initial begin
    int dc;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; cancel = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; a = '0; b = '0; hi_wdata = '0; lo_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);

    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, {32'hFFFF_FFFE, 32'h0000_0001});
    wait_result("multu", 1);
    issue(2'b01, 32'hFFFF_FFFD, 32'd7, 1, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    wait_result("mult", 1);
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, 1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    wait_result("div", 1);
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1, {32'h0000_0000, 32'h8000_0000});
    wait_result("div_ovf", 1);
    issue(2'b10, 32'd123, 32'd0, 1, {32'd123, 32'hFFFF_FFFF});
    wait_result("divu_zero", 1);

    preload(32'h0000_A5A5, 32'h0000_5A5A);
    check("mthi", {32'd0, hi}, 64'h0000_A5A5);
    check("mtlo", {32'd0, lo}, 64'h0000_5A5A);

    // mt write in the start cycle lands first, then the result overwrites it
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6; mthi = 1'b1; hi_wdata = 32'h1234_5678;
    exp_q.push_back({32'd0, 32'd30});
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
    check("mt_with_start", {32'd0, hi}, 64'h1234_5678);
    wait_result("mt_start_op", 0);

    // cancel mid-operation
    preload(32'd1, 32'd2);
    dc = done_cnt;
    issue(2'b00, 32'h1111_1111, 32'h2222_2222, 0, 64'd0);
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk); #1 cancel = 1'b0;
    check("cancel_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("cancel_hi", {32'd0, hi}, 64'd1);
    check("cancel_lo", {32'd0, lo}, 64'd2);
    check("cancel_no_done", done_cnt, dc);

    // reset mid-operation
    preload(32'd1, 32'd2);
    issue(2'b01, 32'h0000_0100, 32'h0000_0200, 0, 64'd0);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    check("rstmid_hi", {32'd0, hi}, 64'd0);
    check("rstmid_lo", {32'd0, lo}, 64'd0);
    check("rstmid_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(posedge clk);
    #1 check("rstmid_no_done", done_cnt, dc);

    // second start while busy is dropped
    dc = done_cnt;
    issue(2'b10, 32'd1000, 32'd7, 1, {32'd6, 32'd142});
    repeat (5) @(posedge clk);
    #1 start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
    @(posedge clk); #1 start = 1'b0;
    wait_result("busy_start", 0);
    repeat (40) @(posedge clk);
    #1 check("one_done_only", done_cnt - dc, 1);

    for (int i = 0; i < 6; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : $urandom;
      if (i == 1) rb = 32'hFFFF_FFFF;
      issue(ro, ra, rb, 1, model(ro, ra, rb));
      wait_result("rand", 1);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
